path_lock_arbiter: RTL and testbench
====================================

Name: path_lock_arbiter

Overview:
- Central lock manager for the 64-entry tour array shared by the parallel 2-opt/adjacent-swap solvers.
- Replaces optimistic lock-then-verify with a round-robin arbiter. It grants exclusive ownership of a set of path positions to one requester at a time, with no conflicts.
- Each solver presents a position mask, waits for a grant, runs its check/swap, then releases.
- Sits between the solver FSMs and the path register file in the tsp top level.

Parameters:
- NUM_REQ, 7, number of requesting solvers (5 non-adjacent + 2 adjacent).
- NUM_POS, 64, number of lockable path positions.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NUM_REQ  request from solver i. Held high until gnt[i] is seen.
- mask  in  NUM_REQ*NUM_POS  flattened; bits [i*NUM_POS +: NUM_POS] are the positions wanted by solver i. The solver precomputes wrap-around (e.g. v-1 at v=0 gives bit 63). Stable while req[i]=1.
- rel  in  NUM_REQ  one-cycle pulse: solver i releases everything it holds.
- gnt  out  NUM_REQ  registered one-cycle grant pulse; at most one bit set.
- holding  out  NUM_REQ  bit i = 1 while solver i owns a lock set.
- locked  out  NUM_POS  union of all currently owned positions.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, async): gnt=0, holding=0, locked=0, err=0, all per-requester held masks=0, round-robin pointer ptr=0.
- Eligibility, evaluated each cycle on current registered state: requester i is eligible iff all of
  - req[i]=1;
  - holding[i]=0;
  - mask_i != 0;
  - (mask_i & locked) == 0.
- Arbitration:
  - Scan i = ptr, ptr+1, ... mod NUM_REQ; the first eligible requester wins. At most one grant per cycle.
  - On a grant to i, at the next edge:
    - gnt[i]=1 for exactly one cycle;
    - held_i<=mask_i and holding[i]<=1;
    - locked<=locked | mask_i;
    - ptr<=(i+1) mod NUM_REQ.
  - No eligible requester: gnt=0 and ptr unchanged.
- Latency: req sampled at edge t with no conflict gives gnt at t+1. The lock is already reflected in locked at t+1.
- Release:
  - rel[i] with holding[i]=1 clears held_i and holding[i] at the next edge.
  - locked is recomputed as the OR of all held masks.
  - Freed positions become grantable in the cycle after the release edge, never in the same cycle.
- Simultaneous rel[i] and grant to j on overlapping positions cannot occur: locked is still set when the grant is evaluated.
- req[i] while holding[i]=1 is ignored, with no error; the solver drops req on gnt.
- Protocol errors set err=1 (sticky until reset) and change no other state:
  - rel[i] while holding[i]=0;
  - req[i]=1 with mask_i=0.
- Starvation bound: a continuously requesting solver whose mask is eventually conflict-free is granted within NUM_REQ eligible cycles.
- Invariant: held masks are pairwise disjoint at all times.
- Reset mid-operation: all locks are dropped at once; in-flight solvers must return to their idle state (tsp is reset by the same rst).

Optional Feature:
- Macro PATH_LOCK_STATS_EN.
- Defined: adds two 32-bit outputs.
  - grant_cnt: +1 per grant.
  - conflict_cnt: +1 per cycle in which at least one req[i] with holding[i]=0 and nonzero mask is blocked only by overlap with locked.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then single request: req[0]=1, mask_0=bits{62,63,0} -> gnt[0] one cycle later, holding=7'b0000001, locked=64'hC000_0000_0000_0001.
- Conflict then release:
  - Stimulus: solver 0 holds {5,6,7}; solver 3 requests {7,8}; rel[0] pulsed at cycle 10.
  - Required: no gnt[3] before cycle 11, gnt[3] at cycle 12, final locked={7,8}.
- Round-robin fairness: all 7 request disjoint masks simultaneously from ptr=0 -> grants in order 0,1,...,6 on consecutive cycles, one per cycle, ptr ends at 0.
- Rotation under repeated conflict:
  - Stimulus: solvers 1 and 2 both request {20}, each releasing 2 cycles after its grant, over 6 rounds.
  - Required: grants alternate 1,2,1,2,... with neither granted twice in a row.
- Protocol errors: rel[4] with holding[4]=0, or req[5] with mask_5=0 -> err=1, with locked, holding and gnt unchanged. err stays 1 until rst=0.
- Async reset while 3 solvers hold locks: drive rst=0 mid-cycle -> locked, holding, gnt and err go to 0 immediately without a clock edge. After release of reset, the first grant goes to the lowest eligible index.

Source files
------------

// File: rtl/path_lock_arbiter.sv
// path_lock_arbiter
//   Round-robin lock manager for the shared tour array. Each solver presents
//   a position mask. The arbiter grants exclusive ownership of those positions
//   to one eligible solver per cycle. The solver keeps ownership until it
//   pulses rel.
//
//   Optional build macro: PATH_LOCK_STATS_EN adds the grant_cnt and
//   conflict_cnt counters. Both counters saturate.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   req          per-solver request, held until gnt is seen
//   mask         flattened per-solver position masks, [i*NUM_POS +: NUM_POS]
//   rel          per-solver one-cycle release pulse
//   gnt          registered one-cycle grant pulse, at most one bit set
//   holding      bit i set while solver i owns a lock set
//   locked       union of all currently owned positions
//   err          sticky protocol-error flag
//   grant_cnt    (stats build) number of grants
//   conflict_cnt (stats build) cycles with a request blocked only by overlap
module path_lock_arbiter #(
  parameter int NUM_REQ = 7,
  parameter int NUM_POS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*NUM_POS-1:0] mask,
  input  logic [NUM_REQ-1:0]         rel,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         holding,
  output logic [NUM_POS-1:0]         locked,
  output logic                       err
`ifdef PATH_LOCK_STATS_EN
  ,
  output logic [31:0]                grant_cnt,
  output logic [31:0]                conflict_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_POS-1:0] held     [NUM_REQ];
  logic [NUM_POS-1:0] held_nxt [NUM_REQ];
  logic [NUM_POS-1:0] m        [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] blocked;
  logic [NUM_REQ-1:0] holding_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [NUM_POS-1:0] locked_nxt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_nxt;
  logic [PW-1:0]      win;
  logic               found;
  logic               proto_err;

  // Decode the masks and evaluate eligibility against the registered lock state.
  always_comb begin
    proto_err = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      m[i]        = mask[i*NUM_POS +: NUM_POS];
      eligible[i] = req[i] && !holding[i] && (|m[i]) && !(|(m[i] & locked));
      blocked[i]  = req[i] && !holding[i] && (|m[i]) &&  (|(m[i] & locked));
      if (rel[i] && !holding[i]) proto_err = 1'b1;
      if (req[i] && !(|m[i]))    proto_err = 1'b1;
    end
  end

  // Rotating priority scan: the first eligible index at or after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned idx;
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Next lock state. A release and a grant can both occur in the same cycle.
  // They cannot overlap, because the grant was evaluated against the
  // registered locked, which still includes the positions being released.
  always_comb begin
    gnt_nxt     = '0;
    holding_nxt = holding;
    locked_nxt  = '0;
    ptr_nxt     = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      held_nxt[i] = held[i];
      if (rel[i] && holding[i]) begin
        held_nxt[i]    = '0;
        holding_nxt[i] = 1'b0;
      end
      if (found && (win == PW'(i))) begin
        held_nxt[i]    = m[i];
        holding_nxt[i] = 1'b1;
        gnt_nxt[i]     = 1'b1;
      end
      locked_nxt = locked_nxt | held_nxt[i];
    end
    if (found) ptr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) held[i] <= '0;
      gnt     <= '0;
      holding <= '0;
      locked  <= '0;
      err     <= 1'b0;
      ptr     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) held[i] <= held_nxt[i];
      gnt     <= gnt_nxt;
      holding <= holding_nxt;
      locked  <= locked_nxt;
      ptr     <= ptr_nxt;
      if (proto_err) err <= 1'b1;
    end
  end

`ifdef PATH_LOCK_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (found && (grant_cnt != '1))        grant_cnt    <= grant_cnt + 32'd1;
      if ((|blocked) && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`else
  logic unused_blocked;
  assign unused_blocked = ^blocked;
`endif

endmodule

// File: tb/tb_path_lock_arbiter.sv
// Testbench for path_lock_arbiter. Directed scenarios and a random phase both
// drive solver behaviour. A reference model predicts the outputs for every
// cycle, and a negedge monitor compares those predictions against the DUT.
module tb_path_lock_arbiter;
  localparam int NR = 7;
  localparam int NP = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     rel = '0;
  logic [NR*NP-1:0]  mask = '0;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     holding;
  logic [NP-1:0]     locked;
  logic              err;
`ifdef PATH_LOCK_STATS_EN
  logic [31:0]       grant_cnt;
  logic [31:0]       conflict_cnt;
`endif

  path_lock_arbiter #(.NUM_REQ(NR), .NUM_POS(NP)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .rel(rel),
    .gnt(gnt), .holding(holding), .locked(locked), .err(err)
`ifdef PATH_LOCK_STATS_EN
    , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard entries. Each entry holds the outputs expected after edge 'due'.
  typedef struct {
    int            due;
    logic [NR-1:0] g;
    logic [NR-1:0] h;
    logic [NP-1:0] l;
    logic          e;
  } exp_t;
  exp_t sbq[$];

  // Grants observed on the DUT, with the cycle of each, for the ordering checks.
  bit             rec = 1'b0;
  logic [NR-1:0]  gq[$];
  int             gcyc[$];

  always @(negedge clk) begin
    if (rst) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("gnt",     64'(gnt),     64'(e.g));
        chk("holding", 64'(holding), 64'(e.h));
        chk("locked",  locked,       e.l);
        chk("err",     64'(err),     64'(e.e));
      end
      if (rec && gnt != '0) begin
        gq.push_back(gnt);
        gcyc.push_back(cyc);
      end
    end
  end

  // Reference model: owned mask per solver, rotating start index, sticky error.
  logic [NP-1:0] m_held [NR];
  int            m_ptr;
  logic          m_err;

  // Solver engine: 0 idle, 1 requesting, 2 holding.
  int            st       [NR];
  logic [NP-1:0] smask    [NR];
  int            hold_left[NR];
  int            hold_len [NR];
  int            rounds   [NR];
  bit            rnd = 1'b0;
  logic [NR-1:0] frel = '0;

  task automatic reset_model();
    for (int i = 0; i < NR; i++) begin
      m_held[i] = '0; st[i] = 0; smask[i] = '0;
      hold_left[i] = 0; hold_len[i] = 0; rounds[i] = 0;
    end
    m_ptr = 0; m_err = 1'b0; rnd = 1'b0; frel = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sbq.delete();
    reset_model();
    req = '0; rel = '0; mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step();
    logic [NR-1:0] rq, rl, g;
    logic [NP-1:0] lk;
    int w, idx, start, len;
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      rq[i] = (st[i] == 1);
      rl[i] = (st[i] == 2 && hold_left[i] <= 0) || frel[i];
      mask[i*NP +: NP] = smask[i];
    end
    req = rq; rel = rl;
    // Predict the outputs after the coming edge.
    lk = '0;
    for (int i = 0; i < NR; i++) lk = lk | m_held[i];
    for (int i = 0; i < NR; i++) begin
      if (rl[i] && m_held[i] == '0) m_err = 1'b1;
      if (rq[i] && smask[i] == '0)  m_err = 1'b1;
    end
    w = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (w < 0 && rq[idx] && m_held[idx] == '0 && smask[idx] != '0 && (smask[idx] & lk) == '0)
        w = idx;
    end
    for (int i = 0; i < NR; i++)
      if (rl[i] && m_held[i] != '0) m_held[i] = '0;
    g = '0;
    if (w >= 0) begin
      m_held[w] = smask[w];
      g[w] = 1'b1;
      m_ptr = (w + 1) % NR;
    end
    e.due = cyc + 1; e.g = g; e.e = m_err; e.l = '0;
    for (int i = 0; i < NR; i++) begin
      e.h[i] = (m_held[i] != '0);
      e.l = e.l | m_held[i];
    end
    sbq.push_back(e);
    // Update the solver engine.
    for (int i = 0; i < NR; i++) begin
      if (rl[i] && st[i] == 2) begin
        st[i] = 0;
        if (rounds[i] > 0) begin rounds[i]--; st[i] = 1; end
      end else if (st[i] == 2) hold_left[i]--;
      if (g[i]) begin st[i] = 2; hold_left[i] = hold_len[i]; end
      if (rnd && st[i] == 0 && !rl[i] && $urandom_range(0, 3) == 0) begin
        start = $urandom_range(0, NP-1);
        len   = $urandom_range(1, 4);
        smask[i] = '0;
        for (int j = 0; j < len; j++) smask[i][(start + j) % NP] = 1'b1;
        hold_len[i] = $urandom_range(0, 5);
        st[i] = 1;
      end
    end
    frel = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    gq.delete(); gcyc.delete(); rec = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int relc, c3;
    // Check the outputs while reset is asserted.
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_holding", 64'(holding), 64'd0);
    chk("rst_locked", locked, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b1;

    // Single request with a wrap-around mask.
    smask[0] = 64'hC000_0000_0000_0001; hold_len[0] = 1000; st[0] = 1;
    step();
    chk("s1_gnt", 64'(gnt), 64'h1);
    chk("s1_holding", 64'(holding), 64'h1);
    chk("s1_locked", locked, 64'hC000_0000_0000_0001);
    step();
    chk("s1_gnt_pulse", 64'(gnt), 64'h0);

    // A conflicting request waits until the holder releases.
    do_reset();
    smask[0] = 64'hE0; hold_len[0] = 1000; st[0] = 1;
    step();
    clear_rec();
    smask[3] = 64'h180; hold_len[3] = 1000; st[3] = 1;
    repeat (3) step();
    hold_left[0] = 0;
    relc = cyc;
    repeat (4) step();
    c3 = -1;
    foreach (gq[k]) if (c3 < 0 && gq[k][3]) c3 = gcyc[k];
    chk("s2_gnt3_cycle", 64'(c3), 64'(relc + 2));
    chk("s2_locked", locked, 64'h180);

    // Round-robin order with disjoint masks.
    do_reset();
    clear_rec();
    for (int i = 0; i < NR; i++) begin
      smask[i] = 64'd1 << (i * 9); hold_len[i] = 1000; st[i] = 1;
    end
    repeat (9) step();
    chk("s3_count", 64'(gq.size()), 64'd7);
    for (int k = 0; k < 7 && k < gq.size(); k++) begin
      chk("s3_order", 64'(gq[k]), 64'd1 << k);
      if (k > 0) chk("s3_consec", 64'(gcyc[k] - gcyc[k-1]), 64'd1);
    end
    for (int i = 0; i < NR; i++) hold_left[i] = 0;
    repeat (2) step();
    clear_rec();
    st[6] = 1; st[0] = 1;
    repeat (2) step();
    chk("s3_ptr_wrap", (gq.size() > 0) ? 64'(gq[0]) : 64'hDEAD, 64'h1);

    // Two solvers contend repeatedly for the same position.
    do_reset();
    clear_rec();
    smask[1] = 64'd1 << 20; smask[2] = 64'd1 << 20;
    hold_len[1] = 2; hold_len[2] = 2; rounds[1] = 5; rounds[2] = 5;
    st[1] = 1; st[2] = 1;
    repeat (90) step();
    chk("s4_count", 64'(gq.size()), 64'd12);
    chk("s4_first", (gq.size() > 0) ? 64'(gq[0]) : 64'hDEAD, 64'h2);
    for (int k = 1; k < gq.size(); k++)
      chk("s4_alternate", 64'(gq[k]), (gq[k-1] == 7'b0000010) ? 64'h4 : 64'h2);

    // Protocol error: release without holding anything.
    do_reset();
    smask[0] = 64'hF; hold_len[0] = 1000; st[0] = 1;
    repeat (2) step();
    frel[4] = 1'b1;
    step();
    chk("s5_err_rel", 64'(err), 64'h1);
    chk("s5_holding", 64'(holding), 64'h1);
    chk("s5_locked", locked, 64'hF);
    chk("s5_gnt", 64'(gnt), 64'h0);
    // Protocol error: request with an empty mask. The error flag must stay set.
    do_reset();
    chk("s5_err_cleared", 64'(err), 64'h0);
    st[5] = 1; smask[5] = '0;
    step();
    st[5] = 0;
    repeat (5) step();
    chk("s5_err_sticky", 64'(err), 64'h1);
    chk("s5_locked_empty", locked, 64'h0);

    // Asynchronous reset while three solvers hold locks.
    do_reset();
    smask[1] = 64'h3; smask[2] = 64'h30; smask[4] = 64'h300;
    for (int i = 0; i < NR; i++) hold_len[i] = 1000;
    st[1] = 1; st[2] = 1; st[4] = 1;
    repeat (5) step();
    chk("s6_holding_pre", 64'(holding), 64'h16);
    #2;
    rst = 1'b0;
    sbq.delete();
    #1;
    chk("s6_async_gnt", 64'(gnt), 64'h0);
    chk("s6_async_holding", 64'(holding), 64'h0);
    chk("s6_async_locked", locked, 64'h0);
    chk("s6_async_err", 64'(err), 64'h0);
    do_reset();
    clear_rec();
    smask[3] = 64'h3; smask[5] = 64'h30; smask[6] = 64'h300;
    for (int i = 0; i < NR; i++) hold_len[i] = 1000;
    st[6] = 1; st[5] = 1; st[3] = 1;
    repeat (3) step();
    chk("s6_first_after_reset", (gq.size() > 0) ? 64'(gq[0]) : 64'hDEAD, 64'h8);

    // Random traffic checked by the scoreboard.
    do_reset();
    rec = 1'b0;
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    @(negedge clk);
    #1;
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
